host_uart_link: RTL and testbench
=================================

// Module: host_uart_link
// PURPOSE
//  Host-side peer of the AVR core's serial port: fixed-rate 8N1 UART endpoint wired to the AVR's
//  tx_o/rx_i pins. Converts host byte streams (valid/ready) to serial frames and back.
//  16x oversampled receiver feeds an RX FIFO; transmitter holds one byte at a time.
// PARAMETERS
//  BAUD_DIV      4    clk_i cycles per 1/16 bit (bit time = 16*BAUD_DIV clocks), >=1
//  RX_FIFO_DEPTH 16   RX FIFO entries, power of 2, >=2
// PORTS
//  clk_i            in   1   single clock; all logic on posedge
//  rst_n_i          in   1   reset, synchronous, active-low
//  tx_data_i        in   8   byte to transmit
//  tx_valid_i       in   1   tx_data_i valid
//  tx_ready_o       out  1   transmitter idle; byte accepted on tx_valid_i & tx_ready_o
//  rx_data_o        out  8   FIFO head byte
//  rx_valid_o       out  1   FIFO not empty
//  rx_ready_i       in   1   pop head on rx_valid_o & rx_ready_i
//  rx_level_o       out  $clog2(RX_FIFO_DEPTH)+1  FIFO occupancy
//  rx_frame_err_o   out  1   1-cycle pulse: stop bit sampled low
//  rx_overrun_o     out  1   1-cycle pulse: byte received while FIFO full (byte dropped)
//  rx_i             in   1   serial in (from AVR tx_o), asynchronous
//  tx_o             out  1   serial out (to AVR rx_i)
// BEHAVIOUR
//  Reset (rst_n_i=0 at clk edge): tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_level_o=0, pulses 0,
//   rx synchroniser flops=1, both FSMs IDLE, dividers 0. Reset mid-frame aborts it; tx_o returns high.
//  Frame: start(0), 8 data LSB first, 1 stop(1); no parity. Every bit is 16 oversample ticks.
//  TX: own divider, reloaded on accept. TX_IDLE -> accept -> TX_START (tx_o=0 next cycle, tx_ready_o=0)
//   -> TX_DATA x8 -> TX_STOP -> TX_IDLE. Each state holds exactly 16*BAUD_DIV clocks; tx_ready_o
//   rises the cycle after stop bit ends (accept-to-ready = 160*BAUD_DIV clocks). tx_data_i latched on accept.
//  RX: rx_i through 2-flop synchroniser. Free-running divider gives tick every BAUD_DIV clocks.
//   RX_IDLE: tick & line low -> RX_START, sample_cnt=0. RX_START: at sample_cnt==7 line low ->
//   RX_DATA, else RX_IDLE (glitch). RX_DATA: sample at each mid-bit (every 16 ticks), shift LSB first,
//   after 8th bit -> RX_STOP. RX_STOP mid-bit: line high -> push byte, RX_IDLE;
//   line low -> rx_frame_err_o pulse, byte discarded, RX_BREAK. RX_BREAK: wait line high -> RX_IDLE.
//  FIFO: push to rx_valid_o latency 1 cycle. Push when full and no pop -> drop + rx_overrun_o.
//   Push & pop same cycle when full -> both succeed, level unchanged. Pointers wrap mod depth.
//   rx_data_o stable while rx_valid_o & ~rx_ready_i.
//  TX and RX fully independent (full duplex).
// CONFIGURATION
//  HOST_UART_RX_FILTER_EN defined: every RX sample (start check, data, stop) = majority of
//   oversample ticks 6,7,8 of the bit. Undefined: single sample at tick 7. Timing otherwise identical.
// STRUCTURE
//  host_uart_pkg: OVERSAMPLE=16, DATA_BITS=8, MID_SAMPLE=7, tx/rx state enums.
//  Sub-module host_uart_fifo (sync FIFO, DEPTH param, push/pop/full/empty/level); rest inline.
// TESTING (BAUD_DIV=4 -> 64 clocks/bit)
//  1 Reset: hold rst_n_i=0 3 cycles -> tx_o=1, tx_ready_o=1, rx_valid_o=0, rx_level_o=0.
//  2 TX 0xA5: tx_o low 64 clks, then 1,0,1,0,0,1,0,1 at 64 clks each, high stop; tx_ready_o after 640.
//  3 Loopback tx_o->rx_i, send 0x3C -> rx_valid_o=1, rx_data_o=0x3C, rx_level_o=1, no err pulses.
//  4 Drive 0x55 with stop bit 0 -> one rx_frame_err_o pulse, level stays 0, no new byte until line high.
//  5 rx_ready_i=0, send 17 bytes 0x00..0x10 -> level 16, one rx_overrun_o on 17th; pops give 0x00..0x0F.
//  6 Low glitch of 12 clocks (3 ticks) on idle line -> no byte, no error; with _EN, 1-tick low spike
//    inside a 0xFF data bit -> still received 0xFF.

Source files
------------

// File: rtl/host_uart_pkg.sv
// Shared constants, FSM state types and helpers for the host-side UART link.
package host_uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned MID_SAMPLE = 7;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/host_uart_link_if.sv
// Host-facing byte-stream bundle of host_uart_link: TX valid/ready, RX valid/ready, RX status.
interface host_uart_link_if
    import host_uart_pkg::*;
#(
    parameter int unsigned RX_FIFO_DEPTH = 16
);
    localparam int unsigned LEVEL_W = $clog2(RX_FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic [LEVEL_W-1:0]   rx_level_o;
    logic                 rx_frame_err_o;
    logic                 rx_overrun_o;

    modport master (
        output tx_data_i, tx_valid_i, rx_ready_i,
        input  tx_ready_o, rx_data_o, rx_valid_o, rx_level_o, rx_frame_err_o, rx_overrun_o
    );

    modport slave (
        input  tx_data_i, tx_valid_i, rx_ready_i,
        output tx_ready_o, rx_data_o, rx_valid_o, rx_level_o, rx_frame_err_o, rx_overrun_o
    );

endinterface

// File: rtl/host_uart_fifo.sv
// Synchronous FIFO for received bytes; a push into a full FIFO is accepted only alongside a pop.
module host_uart_fifo
    import host_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/host_uart_link.sv
// Host-side 8N1 UART endpoint: byte-stream TX serialiser and 16x oversampled RX into a FIFO.
// Optional HOST_UART_RX_FILTER_EN: every RX decision is a 3-tick majority vote.
module host_uart_link
    import host_uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV      = 4,
    parameter int unsigned RX_FIFO_DEPTH = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    host_uart_link_if.slave host,
    input  logic           rx_i,
    output logic           tx_o
);
    localparam int unsigned BIT_CLKS = OVERSAMPLE * BAUD_DIV;
    localparam int unsigned BW       = $clog2(BIT_CLKS);
    localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);
    localparam int unsigned TW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);

    // ---------------- transmitter ----------------
    tx_state_t            tx_state, tx_state_next;
    logic [BW-1:0]        tx_div, tx_div_next;
    logic [2:0]           tx_bit, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_next;
    logic                 tx_line, tx_line_next;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_state <= TX_IDLE;
            tx_div   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_div   <= tx_div_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            tx_line  <= tx_line_next;
        end
    end

    // The serial line is registered from the next state so it changes together with the state.
    always_comb begin
        tx_state_next = tx_state;
        tx_div_next   = tx_div;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_line_next  = tx_line;
        case (tx_state)
            TX_IDLE: begin
                tx_line_next = 1'b1;
                if (host.tx_valid_i) begin
                    tx_state_next = TX_START;
                    tx_div_next   = '0;
                    tx_shift_next = host.tx_data_i;
                    tx_line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_div == BIT_LAST) begin
                    tx_state_next = TX_DATA;
                    tx_div_next   = '0;
                    tx_bit_next   = '0;
                    tx_line_next  = tx_shift[0];
                end else begin
                    tx_div_next = tx_div + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_div == BIT_LAST) begin
                    tx_div_next = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_next = TX_STOP;
                        tx_line_next  = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit + 1'b1;
                        tx_shift_next = tx_shift >> 1;
                        tx_line_next  = tx_shift[1];
                    end
                end else begin
                    tx_div_next = tx_div + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_div == BIT_LAST) begin
                    tx_state_next = TX_IDLE;
                    tx_div_next   = '0;
                    tx_line_next  = 1'b1;
                end else begin
                    tx_div_next = tx_div + 1'b1;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
                tx_line_next  = 1'b1;
            end
        endcase
    end

    assign tx_o            = tx_line;
    assign host.tx_ready_o = (tx_state == TX_IDLE);

    // ---------------- receiver front end ----------------
    logic [1:0]    rx_sync;
    logic          rx_line;
    logic [TW-1:0] tick_div;
    logic          tick;
    logic          rx_bit;
    logic          sample_now;
    logic [3:0]    rx_cnt, rx_cnt_next;

    assign rx_line = rx_sync[1];
    assign tick    = (tick_div == TICK_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_sync  <= 2'b11;
            tick_div <= '0;
        end else begin
            rx_sync  <= {rx_sync[0], rx_i};
            tick_div <= tick ? '0 : tick_div + 1'b1;
        end
    end

`ifdef HOST_UART_RX_FILTER_EN
    // Decide one tick later so ticks MID_SAMPLE-1, MID_SAMPLE and MID_SAMPLE+1 are all available.
    localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE + 1);
    logic [1:0] rx_hist;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_hist <= 2'b11;
        end else if (tick) begin
            rx_hist <= {rx_hist[0], rx_line};
        end
    end

    assign rx_bit = majority3(rx_hist[1], rx_hist[0], rx_line);
`else
    localparam logic [3:0] DECIDE_CNT = 4'(MID_SAMPLE);
    assign rx_bit = rx_line;
`endif

    assign sample_now = tick & (rx_cnt == DECIDE_CNT);

    // ---------------- receiver FSM ----------------
    rx_state_t            rx_state, rx_state_next;
    logic [2:0]           rx_bitn, rx_bitn_next;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_next;
    logic                 rx_push;
    logic                 frame_err_next;
    logic                 frame_err;
    logic                 overrun;
    logic                 fifo_full;
    logic                 fifo_empty;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bitn   <= '0;
            rx_shift  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_state  <= rx_state_next;
            rx_cnt    <= rx_cnt_next;
            rx_bitn   <= rx_bitn_next;
            rx_shift  <= rx_shift_next;
            frame_err <= frame_err_next;
            overrun   <= rx_push & fifo_full & ~host.rx_ready_i;
        end
    end

    // The tick counter runs modulo 16 across the whole frame, so each mid-bit is 16 ticks apart.
    always_comb begin
        rx_state_next  = rx_state;
        rx_cnt_next    = tick ? rx_cnt + 1'b1 : rx_cnt;
        rx_bitn_next   = rx_bitn;
        rx_shift_next  = rx_shift;
        rx_push        = 1'b0;
        frame_err_next = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (tick && !rx_line) rx_state_next = RX_START;
            end
            RX_START: begin
                if (sample_now) begin
                    if (!rx_bit) begin
                        rx_state_next = RX_DATA;
                        rx_bitn_next  = '0;
                    end else begin
                        rx_state_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (sample_now) begin
                    rx_shift_next = {rx_bit, rx_shift[DATA_BITS-1:1]};
                    if (rx_bitn == 3'd7) rx_state_next = RX_STOP;
                    else                 rx_bitn_next  = rx_bitn + 1'b1;
                end
            end
            RX_STOP: begin
                if (sample_now) begin
                    if (rx_bit) begin
                        rx_push       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        rx_state_next  = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_line) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    host_uart_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_rx_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (host.rx_ready_i),
        .head      (host.rx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (host.rx_level_o)
    );

    assign host.rx_valid_o     = ~fifo_empty;
    assign host.rx_frame_err_o = frame_err;
    assign host.rx_overrun_o   = overrun;

endmodule

// File: tb/tb_host_uart_link.sv
// Directed bench for host_uart_link at BAUD_DIV=4 (64 clocks per bit), 16-entry RX FIFO.
module tb_host_uart_link;
    import host_uart_pkg::*;

    localparam int unsigned BAUD_DIV = 4;
    localparam int unsigned DEPTH    = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_pin;
    logic tx_pin;
    logic rx_drv;
    logic loop_en;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned fe_cnt   = 0;
    int unsigned ov_cnt   = 0;
    int unsigned fe0;
    int unsigned ov0;

    host_uart_link_if #(.RX_FIFO_DEPTH(DEPTH)) host ();

    host_uart_link #(
        .BAUD_DIV      (BAUD_DIV),
        .RX_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .host    (host),
        .rx_i    (rx_pin),
        .tx_o    (tx_pin)
    );

    assign rx_pin = loop_en ? tx_pin : rx_drv;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (host.rx_frame_err_o === 1'b1) fe_cnt <= fe_cnt + 1;
        if (host.rx_overrun_o === 1'b1)   ov_cnt <= ov_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx_valid(input int unsigned limit);
        int unsigned n = 0;
        while (host.rx_valid_o !== 1'b1 && n < limit) begin
            cycles(1);
            n++;
        end
    endtask

    task automatic wait_tx_ready(input int unsigned limit);
        int unsigned n = 0;
        while (host.tx_ready_o !== 1'b1 && n < limit) begin
            cycles(1);
            n++;
        end
    endtask

    task automatic send_tx(input logic [7:0] b);
        host.tx_data_i  = b;
        host.tx_valid_i = 1'b1;
        cycles(1);
        host.tx_valid_i = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        rx_drv = 1'b0;
        cycles(64);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            cycles(64);
        end
        rx_drv = stop_bit;
        cycles(64);
    endtask

    task automatic pop_one();
        host.rx_ready_i = 1'b1;
        cycles(1);
        host.rx_ready_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a5;
        a5 = 8'hA5;
        rst_n           = 1'b0;
        loop_en         = 1'b0;
        rx_drv          = 1'b1;
        host.tx_data_i  = '0;
        host.tx_valid_i = 1'b0;
        host.rx_ready_i = 1'b0;

        // reset
        cycles(3);
        check_eq("rst_tx_o", 32'(tx_pin), 32'd1);
        check_eq("rst_tx_ready", 32'(host.tx_ready_o), 32'd1);
        check_eq("rst_rx_valid", 32'(host.rx_valid_o), 32'd0);
        check_eq("rst_rx_level", 32'(host.rx_level_o), 32'd0);
        rst_n = 1'b1;
        cycles(5);

        // TX 0xA5 bit timing
        send_tx(a5);
        check_eq("tx_start_edge", 32'(tx_pin), 32'd0);
        check_eq("tx_busy", 32'(host.tx_ready_o), 32'd0);
        cycles(32);
        check_eq("tx_start_mid", 32'(tx_pin), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycles(64);
            check_eq($sformatf("tx_bit%0d", i), 32'(tx_pin), 32'(a5[i]));
        end
        cycles(64);
        check_eq("tx_stop_mid", 32'(tx_pin), 32'd1);
        cycles(31);
        check_eq("tx_ready_639", 32'(host.tx_ready_o), 32'd0);
        cycles(1);
        check_eq("tx_ready_640", 32'(host.tx_ready_o), 32'd1);

        // loopback 0x3C
        loop_en = 1'b1;
        cycles(2);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_tx(8'h3C);
        wait_rx_valid(800);
        check_eq("lb_valid", 32'(host.rx_valid_o), 32'd1);
        check_eq("lb_data", 32'(host.rx_data_o), 32'h3C);
        check_eq("lb_level", 32'(host.rx_level_o), 32'd1);
        wait_tx_ready(200);
        check_eq("lb_tx_ready", 32'(host.tx_ready_o), 32'd1);
        check_eq("lb_no_ferr", fe_cnt - fe0, 32'd0);
        check_eq("lb_no_ovr", ov_cnt - ov0, 32'd0);
        pop_one();
        check_eq("lb_pop_level", 32'(host.rx_level_o), 32'd0);
        check_eq("lb_pop_valid", 32'(host.rx_valid_o), 32'd0);
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        cycles(20);

        // framing error then break
        fe0 = fe_cnt;
        drive_frame(8'h55, 1'b0);
        cycles(300);
        check_eq("ferr_pulse", fe_cnt - fe0, 32'd1);
        check_eq("ferr_level", 32'(host.rx_level_o), 32'd0);
        check_eq("ferr_valid", 32'(host.rx_valid_o), 32'd0);
        rx_drv = 1'b1;
        cycles(100);
        check_eq("break_level", 32'(host.rx_level_o), 32'd0);
        check_eq("break_one_pulse", fe_cnt - fe0, 32'd1);
        drive_frame(8'h81, 1'b1);
        rx_drv = 1'b1;
        cycles(20);
        check_eq("recover_valid", 32'(host.rx_valid_o), 32'd1);
        check_eq("recover_data", 32'(host.rx_data_o), 32'h81);
        pop_one();

        // fill FIFO past capacity
        ov0 = ov_cnt;
        for (int b = 0; b < 17; b++) begin
            drive_frame(8'(b), 1'b1);
            rx_drv = 1'b1;
            cycles(16);
        end
        cycles(20);
        check_eq("full_level", 32'(host.rx_level_o), 32'd16);
        check_eq("full_overrun", ov_cnt - ov0, 32'd1);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("drain%0d", i), 32'(host.rx_data_o), 32'(i));
            pop_one();
        end
        check_eq("drain_valid", 32'(host.rx_valid_o), 32'd0);
        check_eq("drain_level", 32'(host.rx_level_o), 32'd0);

        // short low glitch on idle line
        fe0 = fe_cnt;
        rx_drv = 1'b0;
        cycles(12);
        rx_drv = 1'b1;
        cycles(200);
        check_eq("glitch_level", 32'(host.rx_level_o), 32'd0);
        check_eq("glitch_no_ferr", fe_cnt - fe0, 32'd0);

        // 0xFF frame; with the filter a one-tick low spike sits inside data bit 3
        rx_drv = 1'b0;
        cycles(64);
        rx_drv = 1'b1;
`ifdef HOST_UART_RX_FILTER_EN
        cycles(64 * 3 + 30);
        rx_drv = 1'b0;
        cycles(4);
        rx_drv = 1'b1;
        cycles(64 * 5 - 34 + 64);
`else
        cycles(64 * 9);
`endif
        cycles(10);
        check_eq("ff_valid", 32'(host.rx_valid_o), 32'd1);
        check_eq("ff_data", 32'(host.rx_data_o), 32'hFF);
        check_eq("ff_no_ferr", fe_cnt - fe0, 32'd0);
        pop_one();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
